stress_threshold_sequencer: RTL and testbench

Time-multiplexes the stress calculator's single shared 8-bit greater-than comparator across all sensor channels. On each `start` it compares every channel sample against its threshold (optionally with hysteresis), counts the channels in excess, and publishes a debounced stress level to the rocking controller. It owns the comparator's operand buses. The comparator itself stays an external combinational instance wired back through `cmp_q`.

---
 rtl/stress_threshold_sequencer.sv | 131 +++++++++++++
 tb/tb_stress_threshold_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/stress_threshold_sequencer.sv
// stress_threshold_sequencer: shares one external 8-bit a>b comparator across all sensor channels and debounces the exceed count
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset, clears all state including debounce history
//   start         in   one-cycle evaluation request, ignored while busy
//   samples       in   8*CHANNELS, channel i at [8i+7:8i]
//   thresholds    in   8*CHANNELS, same packing as samples
//   cmp_a         out  8, comparator operand a (latched sample of the channel being scanned)
//   cmp_b         out  8, comparator operand b (effective threshold of that channel)
//   cmp_q         in   comparator result a>b, combinational from cmp_a/cmp_b
//   busy          out  evaluation in progress
//   done          out  one-cycle pulse when an evaluation completes
//   flags         out  CHANNELS, per-channel exceed result of the last evaluation
//   stress_level  out  3, debounced count of exceeded channels
//   level_changed out  one-cycle pulse with done when stress_level took a new value
//
// Build option: define STRESS_HYSTERESIS_EN to lower a flagged channel's threshold by HYST
// (saturating at 0) on the following evaluation. Without it HYST is unused.
module stress_threshold_sequencer #(
    parameter int CHANNELS = 4,
    parameter int PERSIST  = 3,
    parameter int HYST     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8*CHANNELS-1:0] samples,
    input  logic [8*CHANNELS-1:0] thresholds,
    output logic [7:0]            cmp_a,
    output logic [7:0]            cmp_b,
    input  logic                  cmp_q,
    output logic                  busy,
    output logic                  done,
    output logic [CHANNELS-1:0]   flags,
    output logic [2:0]            stress_level,
    output logic                  level_changed
);
    typedef enum logic [1:0] {IDLE, SCAN, UPDATE} state_t;
    localparam logic [2:0] LAST = 3'(CHANNELS - 1);
    localparam logic [3:0] PMAX = 4'(PERSIST);
`ifdef STRESS_HYSTERESIS_EN
    localparam logic [7:0] HYST8 = 8'(HYST);
`endif
    state_t                state;
    logic [8*CHANNELS-1:0] s_lat;
    logic [8*CHANNELS-1:0] t_lat;
    logic [CHANNELS-1:0]   new_flag;
    logic [2:0]            idx;
    logic [2:0]            cand;
    logic [2:0]            last_cand;
    logic [3:0]            run;
    logic [3:0]            run_next;

    // Operands are decoded from registered state only, so they hold steady for the whole SCAN cycle.
    always_comb begin
        cmp_a = 8'd0;
        cmp_b = 8'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (state == SCAN && idx == 3'(i)) begin
                cmp_a = s_lat[8*i +: 8];
`ifdef STRESS_HYSTERESIS_EN
                cmp_b = flags[i] ? ((t_lat[8*i +: 8] > HYST8) ? t_lat[8*i +: 8] - HYST8 : 8'd0) : t_lat[8*i +: 8];
`else
                cmp_b = t_lat[8*i +: 8];
`endif
            end
        end
    end

    always_comb begin
        cand = 3'd0;
        for (int i = 0; i < CHANNELS; i++)
            cand = cand + {2'b00, new_flag[i]};
        run_next = (cand == last_cand) ? ((run >= PMAX) ? PMAX : run + 4'd1) : 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            s_lat         <= '0;
            t_lat         <= '0;
            new_flag      <= '0;
            idx           <= 3'd0;
            last_cand     <= 3'd0;
            run           <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            flags         <= '0;
            stress_level  <= 3'd0;
            level_changed <= 1'b0;
        end else begin
            done          <= 1'b0;
            level_changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        s_lat    <= samples;
                        t_lat    <= thresholds;
                        new_flag <= '0;
                        idx      <= 3'd0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    for (int i = 0; i < CHANNELS; i++)
                        if (idx == 3'(i))
                            new_flag[i] <= cmp_q;
                    idx <= idx + 3'd1;
                    if (idx == LAST)
                        state <= UPDATE;
                end
                UPDATE: begin
                    // last_cand only moves on a new count, and run restarts at 1 in that case
                    last_cand <= cand;
                    run       <= run_next;
                    if (run_next == PMAX && cand != stress_level) begin
                        stress_level  <= cand;
                        level_changed <= 1'b1;
                    end
                    flags <= new_flag;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stress_threshold_sequencer.sv
// tb_stress_threshold_sequencer: table-driven scoreboard bench for stress_threshold_sequencer
module tb_stress_threshold_sequencer;
    typedef struct {
        logic [31:0] s;
        logic [31:0] t;
        logic [3:0]  f;
        logic [2:0]  lvl;
        logic        lc;
    } vec_t;

`ifdef STRESS_HYSTERESIS_EN
    localparam bit HYS = 1'b1;
`else
    localparam bit HYS = 1'b0;
`endif
    localparam logic [31:0] A_S = {8'd50, 8'd90, 8'd10, 8'd200};
    localparam logic [31:0] A_T = {4{8'd80}};
    localparam logic [31:0] B_T = {8'd80, 8'd80, 8'd5, 8'd80};
    localparam logic [31:0] X_S = {4{8'd255}};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] samples = '0;
    logic [31:0] thresholds = '0;
    logic [7:0]  cmp_a;
    logic [7:0]  cmp_b;
    logic        cmp_q;
    logic        busy;
    logic        done;
    logic [3:0]  flags;
    logic [2:0]  stress_level;
    logic        level_changed;

    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   starts = 0;
    logic [3:0] prev_flags = 4'd0;
    vec_t sb[$];
    vec_t e;
    vec_t tbl[13];
    vec_t hyst[3];

    always #5 clk = ~clk;

    assign cmp_q = cmp_a > cmp_b;

    stress_threshold_sequencer #(.CHANNELS(4), .PERSIST(3), .HYST(8)) dut (
        .clk(clk), .reset(reset), .start(start), .samples(samples), .thresholds(thresholds),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_q(cmp_q), .busy(busy), .done(done),
        .flags(flags), .stress_level(stress_level), .level_changed(level_changed)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] eff(input logic [7:0] t, input logic f);
        return (HYS && f) ? ((t > 8'd8) ? t - 8'd8 : 8'd0) : t;
    endfunction

    // Caller is at a negedge; start is sampled at the next posedge. Returns at the negedge where done is high.
    task automatic run_eval(input vec_t v, input bit poke);
        samples = v.s;
        thresholds = v.t;
        start = 1'b1;
        sb.push_back(v);
        starts++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = poke && k == 2;
            if (poke && k == 1) begin
                samples = ~v.s;
                thresholds = ~v.t;
            end
            chk("busy_scan", busy, 1);
            chk("cmp_a_scan", cmp_a, v.s[8*k +: 8]);
            chk("cmp_b_scan", cmp_b, eff(v.t[8*k +: 8], prev_flags[k]));
        end
        @(negedge clk);
        start = poke;
        chk("busy_update", busy, 1);
        chk("done_early", done, 0);
        chk("cmp_a_update", cmp_a, 0);
        chk("cmp_b_update", cmp_b, 0);
        @(negedge clk);
        start = 1'b0;
        chk("done_latency", done, 1);
        chk("busy_after_done", busy, 0);
        prev_flags = v.f;
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, required no pending evaluation (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("flags", flags, e.f);
                chk("stress_level", stress_level, e.lvl);
                chk("level_changed", level_changed, e.lc);
            end
        end
        if (level_changed && !done) begin
            n_checks++;
            n_fail++;
            $display("FAIL lc_without_done: got level_changed=1 done=0, required done=1 (t=%0t)", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{A_T, A_T, 4'b0000, 3'd0, 1'b0};
        tbl[1]  = '{A_S, A_T, 4'b0101, 3'd0, 1'b0};
        tbl[2]  = '{A_S, B_T, 4'b0111, 3'd0, 1'b0};
        tbl[3]  = '{A_S, A_T, 4'b0101, 3'd0, 1'b0};
        tbl[4]  = '{A_S, B_T, 4'b0111, 3'd0, 1'b0};
        tbl[5]  = '{A_S, A_T, 4'b0101, 3'd0, 1'b0};
        tbl[6]  = '{A_S, A_T, 4'b0101, 3'd0, 1'b0};
        tbl[7]  = '{A_S, A_T, 4'b0101, 3'd2, 1'b1};
        tbl[8]  = '{A_S, A_T, 4'b0101, 3'd2, 1'b0};
        tbl[9]  = '{X_S, 32'd0, 4'b1111, 3'd2, 1'b0};
        tbl[10] = '{X_S, 32'd0, 4'b1111, 3'd2, 1'b0};
        tbl[11] = '{X_S, 32'd0, 4'b1111, 3'd4, 1'b1};
        tbl[12] = '{32'd0, 32'd0, 4'b0000, 3'd4, 1'b0};
        hyst[0] = '{32'd100, 32'd80, 4'b0001, 3'd2, 1'b0};
        hyst[1] = '{32'd75, 32'd80, HYS ? 4'b0001 : 4'b0000, 3'd2, 1'b0};
        hyst[2] = '{32'd72, 32'd80, 4'b0000, 3'd2, 1'b0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", flags, 0);
        chk("rst_level", stress_level, 0);
        chk("rst_lc", level_changed, 0);
        chk("rst_cmp_a", cmp_a, 0);
        chk("rst_cmp_b", cmp_b, 0);

        // back-to-back: each start issued in the done cycle of the previous run
        for (int r = 0; r < 13; r++)
            run_eval(tbl[r], 1'b0);

        // start pulses during SCAN and UPDATE plus input changes mid-scan must be ignored
        run_eval('{A_S, A_T, 4'b0101, 3'd4, 1'b0}, 1'b1);
        repeat (8) @(negedge clk);
        chk("done_vs_starts", done_cnt, starts);

        // reset while scanning idx=2: abort without done, history cleared
        samples = A_S;
        thresholds = A_T;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_cmp_a_idx2", cmp_a, 90);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_flags", flags, 0);
        chk("abort_level", stress_level, 0);
        chk("abort_cmp_a", cmp_a, 0);
        reset = 1'b0;
        prev_flags = 4'd0;
        repeat (8) @(negedge clk);
        chk("abort_no_done", done_cnt, starts);
        run_eval('{A_S, A_T, 4'b0101, 3'd0, 1'b0}, 1'b0);
        run_eval('{A_S, A_T, 4'b0101, 3'd0, 1'b0}, 1'b0);
        run_eval('{A_S, A_T, 4'b0101, 3'd2, 1'b1}, 1'b0);

        // hysteresis corner on channel 0; cmp_b is checked against 72 or 80 inside run_eval
        for (int r = 0; r < 3; r++)
            run_eval(hyst[r], 1'b0);

        repeat (6) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("final_done_count", done_cnt, starts);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
